// File: rtl/uart_pkg.sv
// Shared types and constants for the CoreUART baud-rate controller.
// The optional macro UART_ABAUD_CHECK_EN adds the second-measurement states.
package uart_pkg;

    localparam int BAUD_W = 13;
    localparam int FRAC_W = 3;
    localparam logic [7:0] SYNC_CHAR = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_START,
        ST_MEASURE,
        ST_CALC,
        ST_PEND
`ifdef UART_ABAUD_CHECK_EN
        ,
        ST_WAIT_START2,
        ST_MEASURE2
`endif
    } abaud_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx line plus single-cycle edge pulses
// derived from the synchronized value. Flops reset high to match an idle line.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall,
    output logic rx_rise
);

    logic rx_meta;
    logic rx_s2;
    logic rx_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s2   <= rx_meta;
            rx_prev <= rx_s2;
        end
    end

    assign rx_sync = rx_s2;
    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_rise = ~rx_prev & rx_s2;

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-rate configuration controller: host load or auto-baud on a 0x55 sync
// character, committed only while the UART is idle. Optional macro: UART_ABAUD_CHECK_EN.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int               CNT_W            = 20,
    parameter int               MIN_PERIOD       = 16,
    parameter logic [BAUD_W-1:0] DEFAULT_BAUD_VAL = 13'd1,
    parameter logic [FRAC_W-1:0] DEFAULT_FRAC     = 3'd0,
    parameter int               FRAC_EN          = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    input  logic              autobaud_start,
    input  logic              host_load,
    input  logic [BAUD_W-1:0] host_baud_val,
    input  logic [FRAC_W-1:0] host_baud_frac,
    input  logic              tx_busy,
    input  logic              rx_busy,
    output logic [BAUD_W-1:0] baud_val,
    output logic [FRAC_W-1:0] baud_val_fraction,
    output logic              cfg_pending,
    output logic              autobaud_busy,
    output logic              autobaud_done,
    output logic              autobaud_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    abaud_state_t state, state_next;

    logic rx_sync, rx_fall, rx_rise;

    logic [CNT_W-1:0]  cnt, cnt_plus, p_reg;
    logic [BAUD_W-1:0] stage_bv;
    logic [FRAC_W-1:0] stage_fr;
    logic              stage_auto;

    logic cnt_clr, cnt_inc, p_load, err_set, err_clr;
    logic stage_host, stage_calc, commit;

    logic [31:0]       q_w, q8_w, qr8_w, bv_w;
    logic              calc_err;
    logic [BAUD_W-1:0] calc_bv;
    logic [FRAC_W-1:0] calc_fr;

    uart_rx_sync u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall),
        .rx_rise (rx_rise)
    );

    assign cnt_plus = cnt + CNT_W'(1);

`ifdef UART_ABAUD_CHECK_EN
    logic [CNT_W-1:0] p1_reg, p_diff, p_avg;
    logic             p1_load, diff_bad;

    // Second low period must agree with the first to within one eighth.
    always_comb begin
        p_diff   = (cnt_plus > p1_reg) ? (cnt_plus - p1_reg) : (p1_reg - cnt_plus);
        diff_bad = p_diff > (p1_reg >> 3);
        p_avg    = CNT_W'(({1'b0, p1_reg} + {1'b0, cnt_plus}) >> 1);
    end
`endif

    // Q is the bit period in eighths of a 16x tick, rounded; the divisor is Q/8 - 1.
    always_comb begin
        q_w      = (32'(p_reg) + 32'd1) >> 1;
        q8_w     = q_w >> 3;
        qr8_w    = (q_w + 32'd4) >> 3;
        bv_w     = (FRAC_EN != 0) ? (q8_w - 32'd1) : (qr8_w - 32'd1);
        calc_err = (32'(p_reg) < 32'(MIN_PERIOD)) || (q8_w == 32'd0) ||
                   (bv_w > 32'((1 << BAUD_W) - 1));
        calc_bv  = bv_w[BAUD_W-1:0];
        calc_fr  = (FRAC_EN != 0) ? q_w[FRAC_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Host load overrides everything, including a same-cycle autobaud_start.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        p_load     = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        stage_host = 1'b0;
        stage_calc = 1'b0;
        commit     = 1'b0;
`ifdef UART_ABAUD_CHECK_EN
        p1_load    = 1'b0;
`endif
        if (host_load) begin
            stage_host = 1'b1;
            state_next = ST_PEND;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (autobaud_start) begin
                        err_clr    = 1'b1;
                        state_next = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (rx_sync) state_next = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (rx_fall) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (cnt == CNT_MAX) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                        if (rx_rise) begin
`ifdef UART_ABAUD_CHECK_EN
                            p1_load    = 1'b1;
                            state_next = ST_WAIT_START2;
`else
                            p_load     = 1'b1;
                            state_next = ST_CALC;
`endif
                        end
                    end
                end
`ifdef UART_ABAUD_CHECK_EN
                ST_WAIT_START2: begin
                    if (rx_fall) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_MEASURE2;
                    end
                end
                ST_MEASURE2: begin
                    if (cnt == CNT_MAX) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                        if (rx_rise) begin
                            if (diff_bad) begin
                                err_set    = 1'b1;
                                state_next = ST_IDLE;
                            end else begin
                                p_load     = 1'b1;
                                state_next = ST_CALC;
                            end
                        end
                    end
                end
`endif
                ST_CALC: begin
                    if (calc_err) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stage_calc = 1'b1;
                        state_next = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!tx_busy && !rx_busy) begin
                        commit     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Measurement counter, staged setting and the committed outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt               <= '0;
            p_reg             <= '0;
`ifdef UART_ABAUD_CHECK_EN
            p1_reg            <= '0;
`endif
            stage_bv          <= DEFAULT_BAUD_VAL;
            stage_fr          <= DEFAULT_FRAC;
            stage_auto        <= 1'b0;
            baud_val          <= DEFAULT_BAUD_VAL;
            baud_val_fraction <= DEFAULT_FRAC;
            autobaud_done     <= 1'b0;
            autobaud_err      <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt_plus;
`ifdef UART_ABAUD_CHECK_EN
            if (p1_load) p1_reg <= cnt_plus;
            if (p_load)  p_reg  <= p_avg;
`else
            if (p_load)  p_reg  <= cnt_plus;
`endif
            if (stage_host) begin
                stage_bv   <= host_baud_val;
                stage_fr   <= host_baud_frac;
                stage_auto <= 1'b0;
            end else if (stage_calc) begin
                stage_bv   <= calc_bv;
                stage_fr   <= calc_fr;
                stage_auto <= 1'b1;
            end
            if (commit) begin
                baud_val          <= stage_bv;
                baud_val_fraction <= stage_fr;
            end
            autobaud_done <= commit & stage_auto;
            if (err_clr)      autobaud_err <= 1'b0;
            else if (err_set) autobaud_err <= 1'b1;
        end
    end

    assign cfg_pending   = (state == ST_PEND);
    assign autobaud_busy = (state != ST_IDLE) && (state != ST_PEND);

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl: two instances (fractional and rounded)
// share one stimulus stream; commit expectations go through a scoreboard queue.
module tb_uart_baud_ctrl;

    localparam int BIT = 434;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        autobaud_start = 1'b0;
    logic        host_load = 1'b0;
    logic [12:0] host_baud_val = '0;
    logic [2:0]  host_baud_frac = '0;
    logic        tx_busy = 1'b0;
    logic        rx_busy = 1'b0;

    logic [12:0] baud_val, nf_baud_val;
    logic [2:0]  baud_val_fraction, nf_frac;
    logic        cfg_pending, autobaud_busy, autobaud_done, autobaud_err;
    logic        nf_pending, nf_busy, nf_done, nf_err;

    int nChecks = 0;
    int nFail = 0;
    int doneCnt = 0;
    int nfDoneCnt = 0;

    typedef struct {
        string tag;
        int    bv;
        int    fr;
        int    nfBv;
        int    nfFr;
        int    doneExp;
        int    doneBase;
        int    nfDoneBase;
    } exp_t;

    exp_t sbQueue[$];

    always #5 clk = ~clk;

    uart_baud_ctrl #(
        .CNT_W(12), .MIN_PERIOD(16), .DEFAULT_BAUD_VAL(13'd1), .DEFAULT_FRAC(3'd0), .FRAC_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .autobaud_start(autobaud_start),
        .host_load(host_load), .host_baud_val(host_baud_val), .host_baud_frac(host_baud_frac),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .baud_val(baud_val),
        .baud_val_fraction(baud_val_fraction), .cfg_pending(cfg_pending),
        .autobaud_busy(autobaud_busy), .autobaud_done(autobaud_done), .autobaud_err(autobaud_err)
    );

    uart_baud_ctrl #(
        .CNT_W(12), .MIN_PERIOD(16), .DEFAULT_BAUD_VAL(13'd1), .DEFAULT_FRAC(3'd0), .FRAC_EN(0)
    ) dut_nf (
        .clk(clk), .reset_n(reset_n), .rx(rx), .autobaud_start(autobaud_start),
        .host_load(host_load), .host_baud_val(host_baud_val), .host_baud_frac(host_baud_frac),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .baud_val(nf_baud_val),
        .baud_val_fraction(nf_frac), .cfg_pending(nf_pending),
        .autobaud_busy(nf_busy), .autobaud_done(nf_done), .autobaud_err(nf_err)
    );

    always @(posedge clk) begin
        if (autobaud_done) doneCnt <= doneCnt + 1;
        if (nf_done)       nfDoneCnt <= nfDoneCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic holdRx(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulseStart();
        autobaud_start = 1'b1;
        @(negedge clk);
        autobaud_start = 1'b0;
    endtask

    task automatic hostLoad(input int bv, input int fr);
        host_load = 1'b1;
        host_baud_val = 13'(bv);
        host_baud_frac = 3'(fr);
        @(negedge clk);
        host_load = 1'b0;
    endtask

    // 0x55 LSB first: start(low1) 1 0(low2) 1 0 1 0 1 0 stop
    task automatic send55(input int low1, input int low2);
        holdRx(1'b0, low1);
        holdRx(1'b1, BIT);
        holdRx(1'b0, low2);
        for (int i = 0; i < 3; i++) begin
            holdRx(1'b1, BIT);
            holdRx(1'b0, BIT);
        end
        holdRx(1'b1, BIT + 20);
    endtask

    task automatic pushExp(input string tag, input int bv, input int fr,
                           input int nfBv, input int nfFr, input int doneExp);
        exp_t e;
        e.tag = tag; e.bv = bv; e.fr = fr; e.nfBv = nfBv; e.nfFr = nfFr;
        e.doneExp = doneExp; e.doneBase = doneCnt; e.nfDoneBase = nfDoneCnt;
        sbQueue.push_back(e);
    endtask

    task automatic waitCommit(input int maxCycles);
        exp_t e;
        int   n;
        e = sbQueue.pop_front();
        n = 0;
        while ((cfg_pending || autobaud_busy || (doneCnt - e.doneBase) < e.doneExp) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        check({e.tag, "_timeout"}, 32'(n >= maxCycles), 32'd0);
        check({e.tag, "_bv"}, 32'(baud_val), 32'(e.bv));
        check({e.tag, "_fr"}, 32'(baud_val_fraction), 32'(e.fr));
        check({e.tag, "_done_cnt"}, 32'(doneCnt - e.doneBase), 32'(e.doneExp));
        if (e.nfBv >= 0) begin
            check({e.tag, "_nf_bv"}, 32'(nf_baud_val), 32'(e.nfBv));
            check({e.tag, "_nf_fr"}, 32'(nf_frac), 32'(e.nfFr));
            check({e.tag, "_nf_done_cnt"}, 32'(nfDoneCnt - e.nfDoneBase), 32'(e.doneExp));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_bv", 32'(baud_val), 32'd1);
        check("rst_fr", 32'(baud_val_fraction), 32'd0);
        check("rst_pending", 32'(cfg_pending), 32'd0);
        check("rst_busy", 32'(autobaud_busy), 32'd0);
        check("rst_done", 32'(autobaud_done), 32'd0);
        check("rst_err", 32'(autobaud_err), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Auto-baud at 434 cycles per bit
        pulseStart();
        check("ab_busy", 32'(autobaud_busy), 32'd1);
        pushExp("ab434", 26, 1, 26, 0, 1);
        send55(BIT, BIT);
        waitCommit(100);
        check("ab434_err", 32'(autobaud_err), 32'd0);
        check("ab434_nf_err", 32'(nf_err), 32'd0);

        // Host load held off by a busy transmitter
        tx_busy = 1'b1;
        hostLoad(100, 3);
        repeat (50) @(negedge clk);
        check("host_hold_bv", 32'(baud_val), 32'd26);
        check("host_hold_fr", 32'(baud_val_fraction), 32'd1);
        check("host_hold_pending", 32'(cfg_pending), 32'd1);
        pushExp("host100", 100, 3, -1, -1, 0);
        tx_busy = 1'b0;
        waitCommit(20);

        // Glitch-length low period
        pulseStart();
        holdRx(1'b0, 10);
        holdRx(1'b1, 20);
        holdRx(1'b0, 10);
        holdRx(1'b1, 30);
        check("glitch_err", 32'(autobaud_err), 32'd1);
        check("glitch_busy", 32'(autobaud_busy), 32'd0);
        check("glitch_bv", 32'(baud_val), 32'd100);
        check("glitch_fr", 32'(baud_val_fraction), 32'd3);
        pulseStart();
        check("restart_err_clr", 32'(autobaud_err), 32'd0);

        // Counter saturation
        holdRx(1'b1, 5);
        holdRx(1'b0, 4200);
        holdRx(1'b1, 20);
        check("timeout_err", 32'(autobaud_err), 32'd1);
        check("timeout_busy", 32'(autobaud_busy), 32'd0);
        check("timeout_bv", 32'(baud_val), 32'd100);

        // Host load beats a same-cycle autobaud_start
        host_load = 1'b1;
        autobaud_start = 1'b1;
        host_baud_val = 13'd200;
        host_baud_frac = 3'd5;
        @(negedge clk);
        host_load = 1'b0;
        autobaud_start = 1'b0;
        pushExp("host_vs_start", 200, 5, -1, -1, 0);
        waitCommit(20);
        check("host_vs_start_err", 32'(autobaud_err), 32'd1);

        // Second host load overwrites the staged value
        tx_busy = 1'b1;
        hostLoad(300, 1);
        repeat (5) @(negedge clk);
        hostLoad(400, 2);
        check("overwrite_pending", 32'(cfg_pending), 32'd1);
        check("overwrite_hold_bv", 32'(baud_val), 32'd200);
        pushExp("overwrite", 400, 2, -1, -1, 0);
        tx_busy = 1'b0;
        waitCommit(20);

`ifdef UART_ABAUD_CHECK_EN
        pulseStart();
        send55(BIT, 600);
        check("chk_mismatch_err", 32'(autobaud_err), 32'd1);
        check("chk_mismatch_bv", 32'(baud_val), 32'd400);
        pulseStart();
        pushExp("chk_avg", 26, 2, 26, 0, 1);
        send55(BIT, 436);
        waitCommit(100);
        check("chk_avg_err", 32'(autobaud_err), 32'd0);
`endif

        // Reset in the middle of a measurement
        pulseStart();
        holdRx(1'b0, 100);
        check("mid_measure_busy", 32'(autobaud_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_bv", 32'(baud_val), 32'd1);
        check("mid_rst_fr", 32'(baud_val_fraction), 32'd0);
        check("mid_rst_busy", 32'(autobaud_busy), 32'd0);
        check("mid_rst_pending", 32'(cfg_pending), 32'd0);
        check("mid_rst_nf_bv", 32'(nf_baud_val), 32'd1);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
